// File: rtl/modn_updown_counter.sv
// Modulo-N up/down counter with clamped load, count enable,
// cascade terminal count and an optional one-shot halt mode.
module modn_updown_counter #(
   parameter int MODULUS = 10,
   parameter int WIDTH   = 4,
   parameter int ONESHOT = 0
) (
   input  logic             CLK,
   input  logic             Reset_n,
   input  logic             En,
   input  logic             Up,
   input  logic             Load,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q,
   output logic             TC,
   output logic             Wrap,
   output logic             Done
);

   localparam logic [WIDTH-1:0] TOP     = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
   localparam logic [0:0]       RUN     = 1'b0;
   localparam logic [0:0]       HALT    = 1'b1;

   logic [0:0]       state;
   logic [0:0]       state_nxt;
   logic [WIDTH-1:0] q_nxt;
   logic [WIDTH-1:0] q_inc;
   logic [WIDTH-1:0] q_dec;
   logic [WIDTH-1:0] q_step;
   logic [WIDTH-1:0] term;
   logic [WIDTH-1:0] ld_val;
   logic             at_term;
   logic             wrap_nxt;
   logic             done_nxt;

   // Explicit modulo limits keep Q in range even for MODULUS==2**WIDTH
   assign q_inc   = (Q == TOP)   ? '0  : Q + WIDTH'(1);
   assign q_dec   = (Q == '0)    ? TOP : Q - WIDTH'(1);
   assign q_step  = Up ? q_inc : q_dec;
   assign term    = Up ? TOP : '0;
   assign at_term = (Q == term);
   assign ld_val  = ({1'b0, D} >= MOD_EXT) ? TOP : D;
   assign TC      = En & at_term;

   always_comb begin
      q_nxt     = Q;
      state_nxt = state;
      wrap_nxt  = 1'b0;
      done_nxt  = Done;
      if (Load) begin
         q_nxt     = ld_val;
         state_nxt = RUN;
         done_nxt  = 1'b0;
      end else if (En && state == RUN) begin
         if (ONESHOT != 0) begin
            if (at_term) begin
               state_nxt = HALT;
               done_nxt  = 1'b1;
            end else begin
               q_nxt = q_step;
               if (q_step == term) begin
                  state_nxt = HALT;
                  done_nxt  = 1'b1;
               end
            end
         end else begin
            q_nxt    = q_step;
            wrap_nxt = at_term;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!Reset_n) begin
         Q     <= '0;
         state <= RUN;
         Wrap  <= 1'b0;
         Done  <= 1'b0;
      end else begin
         Q     <= q_nxt;
         state <= state_nxt;
         Wrap  <= wrap_nxt;
         Done  <= done_nxt;
      end
   end

endmodule

// File: tb/tb_modn_updown_counter.sv
// Randomised bench for modn_updown_counter: wrap, one-shot and
// power-of-two instances share stimulus; a two-digit cascade runs alongside.
module tb_modn_updown_counter;

   logic       CLK = 1'b0;
   logic       rst_n, en, up, load, cen;
   logic [3:0] d;

   logic [3:0] q0, q1, q2, ql, qh;
   logic       tc0, tc1, tc2, tcl, tch;
   logic       w0, w1, w2, wl, wh;
   logic       dn0, dn1, dn2, dnl, dnh;

   int n_checks = 0;
   int n_fail   = 0;

   int mods[3] = '{10, 10, 16};
   int oss[3]  = '{0, 1, 0};
   int mq[3];
   int mw[3];
   int md[3];
   int ccnt;

   always #5 CLK = ~CLK;

   modn_updown_counter #(.MODULUS(10), .WIDTH(4), .ONESHOT(0)) u0 (
      .CLK(CLK), .Reset_n(rst_n), .En(en), .Up(up), .Load(load), .D(d),
      .Q(q0), .TC(tc0), .Wrap(w0), .Done(dn0));

   modn_updown_counter #(.MODULUS(10), .WIDTH(4), .ONESHOT(1)) u1 (
      .CLK(CLK), .Reset_n(rst_n), .En(en), .Up(up), .Load(load), .D(d),
      .Q(q1), .TC(tc1), .Wrap(w1), .Done(dn1));

   modn_updown_counter #(.MODULUS(16), .WIDTH(4), .ONESHOT(0)) u2 (
      .CLK(CLK), .Reset_n(rst_n), .En(en), .Up(up), .Load(load), .D(d),
      .Q(q2), .TC(tc2), .Wrap(w2), .Done(dn2));

   modn_updown_counter #(.MODULUS(10), .WIDTH(4), .ONESHOT(0)) ulo (
      .CLK(CLK), .Reset_n(rst_n), .En(cen), .Up(1'b1), .Load(1'b0),
      .D(4'd0), .Q(ql), .TC(tcl), .Wrap(wl), .Done(dnl));

   modn_updown_counter #(.MODULUS(10), .WIDTH(4), .ONESHOT(0)) uhi (
      .CLK(CLK), .Reset_n(rst_n), .En(tcl), .Up(1'b1), .Load(1'b0),
      .D(4'd0), .Q(qh), .TC(tch), .Wrap(wh), .Done(dnh));

   task automatic check(string tag, int obs, int exp);
      n_checks++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s t=%0t got=%0d want=%0d", tag, $time, obs, exp);
      end
   endtask

   // Reference: counter rules applied with plain integer arithmetic
   function automatic void model_step();
      int m, tgt;
      for (int i = 0; i < 3; i++) begin
         m   = mods[i];
         tgt = up ? m - 1 : 0;
         if (!rst_n) begin
            mq[i] = 0; mw[i] = 0; md[i] = 0;
         end else if (load) begin
            mq[i] = (int'(d) >= m) ? m - 1 : int'(d);
            mw[i] = 0; md[i] = 0;
         end else if (en && !(oss[i] != 0 && md[i] != 0)) begin
            mw[i] = 0;
            if (oss[i] != 0) begin
               if (mq[i] != tgt) mq[i] = up ? mq[i] + 1 : mq[i] - 1;
               if (mq[i] == tgt) md[i] = 1;
            end else begin
               mw[i] = (mq[i] == tgt) ? 1 : 0;
               mq[i] = (mq[i] + (up ? 1 : m - 1)) % m;
            end
         end else begin
            mw[i] = 0;
         end
      end
      if (!rst_n) ccnt = 0;
      else if (cen) ccnt = (ccnt + 1) % 100;
   endfunction

   function automatic int exp_tc(int i);
      return (en && mq[i] == (up ? mods[i] - 1 : 0)) ? 1 : 0;
   endfunction

   task automatic tick();
      #1;
      check("tc0", int'(tc0), exp_tc(0));
      check("tc1", int'(tc1), exp_tc(1));
      check("tc2", int'(tc2), exp_tc(2));
      check("tc_lo", int'(tcl), (cen && ccnt % 10 == 9) ? 1 : 0);
      @(posedge CLK);
      model_step();
      #1;
      check("q0", int'(q0), mq[0]);
      check("wrap0", int'(w0), mw[0]);
      check("done0", int'(dn0), 0);
      check("q1", int'(q1), mq[1]);
      check("wrap1", int'(w1), 0);
      check("done1", int'(dn1), md[1]);
      check("q2", int'(q2), mq[2]);
      check("wrap2", int'(w2), mw[2]);
      check("cascade", int'(qh) * 10 + int'(ql), ccnt);
   endtask

   task automatic drive(logic r, logic e, logic u, logic l, logic [3:0] dv);
      rst_n = r; en = e; up = u; load = l; d = dv;
      tick();
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         mq[i] = 0; mw[i] = 0; md[i] = 0;
      end
      ccnt = 0;
      cen  = 1'b1;
      rst_n = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; d = '0;
      @(negedge CLK);
      drive(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
      check("reset_q", int'(q0), 0);
      for (int k = 0; k < 12; k++) drive(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
      drive(1'b1, 1'b0, 1'b1, 1'b1, 4'd0);
      for (int k = 0; k < 12; k++) drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
      drive(1'b1, 1'b1, 1'b1, 1'b1, 4'd4);
      drive(1'b1, 1'b1, 1'b1, 1'b1, 4'd7);
      check("load_wins", int'(q0), 7);
      drive(1'b1, 1'b0, 1'b1, 1'b1, 4'd12);
      check("clamp", int'(q0), 9);
      drive(1'b1, 1'b0, 1'b1, 1'b1, 4'd3);
      drive(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
      drive(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
      drive(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
      drive(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
      check("en_gap", int'(q0), 5);
      drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
      check("dir_flip", int'(q0), 4);
      drive(1'b1, 1'b1, 1'b1, 1'b1, 4'd6);
      drive(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
      check("mid_reset", int'(q0), 0);
      for (int k = 0; k < 14; k++) drive(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
      drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
      drive(1'b1, 1'b1, 1'b1, 1'b1, 4'd2);
      for (int k = 0; k < 3; k++) drive(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
      for (int k = 0; k < 600; k++) begin
         cen = ($urandom_range(0, 4) != 0);
         rst_n = ($urandom_range(0, 79) != 0);
         load = ($urandom_range(0, 19) == 0);
         en = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 15) == 0) up = ~up;
         d = 4'($urandom_range(0, 15));
         tick();
      end
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
